// File: rtl/stream_fifo.sv
// stream_fifo: single-clock valid/ready stream FIFO with fill level, almost-full
// flag and an optional store-and-forward packet mode. In packet mode, packets
// stay invisible until their last beat, and bad or oversize packets are discarded.
module stream_fifo #(
  parameter int DATA_WIDTH  = 256,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int DEPTH_LOG2  = 3,
  parameter int PACKET_MODE = 0,
  parameter int AF_THRESH   = (2 ** DEPTH_LOG2) - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [KEEP_WIDTH-1:0] s_keep,
  input  logic                  s_last,
  input  logic                  s_drop,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [KEEP_WIDTH-1:0] m_keep,
  output logic                  m_last,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   pkt_count,
  output logic                  drop_pulse
);

  localparam int PTR_W   = DEPTH_LOG2 + 1;
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 1;

  localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_LEVEL  = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  localparam logic [0:0] ST_ACCEPT  = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  // Each entry packs {last, keep, data}
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_commit;
  logic [PTR_W-1:0] rd_ptr;
  logic [0:0]       state;

  logic [PTR_W-1:0] wr_ptr_nx;
  logic [PTR_W-1:0] wr_commit_nx;
  logic [PTR_W-1:0] rd_ptr_nx;
  logic [PTR_W-1:0] level_nx;
  logic [0:0]       state_nx;

  logic               full;
  logic               wr_fire;
  logic               rd_fire;
  logic               rd_last;
  logic               store_beat;
  logic               commit_beat;
  logic               drop_pkt;
  logic [ENTRY_W-1:0] rd_entry;

  assign full     = (wr_ptr - rd_ptr) == DEPTH_PTR;
  assign m_valid  = (rd_ptr != wr_commit);
  assign wr_fire  = s_valid && s_ready;
  assign rd_fire  = m_valid && m_ready;
  assign rd_entry = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign rd_last  = rd_fire && rd_entry[ENTRY_W-1];

  // Write-side readiness: DISCARD swallows beats regardless of fill, otherwise backpressure on full
  always_comb begin
    s_ready = 1'b0;
    if (!rst) begin
      if (PACKET_MODE != 0 && state == ST_DISCARD) begin
        s_ready = 1'b1;
      end else begin
        s_ready = !full;
      end
    end
  end

  // Output beat is zeroed whenever nothing committed is waiting at the head
  always_comb begin
    m_data = '0;
    m_keep = '0;
    m_last = 1'b0;
    if (m_valid) begin
      m_data = rd_entry[DATA_WIDTH-1:0];
      m_keep = rd_entry[DATA_WIDTH +: KEEP_WIDTH];
      m_last = rd_entry[ENTRY_W-1];
    end
  end

  // Next-state decode for the write pointers, the commit boundary and the packet FSM
  always_comb begin
    wr_ptr_nx    = wr_ptr;
    wr_commit_nx = wr_commit;
    state_nx     = state;
    store_beat   = 1'b0;
    commit_beat  = 1'b0;
    drop_pkt     = 1'b0;
    if (PACKET_MODE == 0) begin
      if (wr_fire) begin
        store_beat   = 1'b1;
        wr_ptr_nx    = wr_ptr + PTR_ONE;
        wr_commit_nx = wr_ptr + PTR_ONE;
        commit_beat  = s_last;
      end
    end else if (state == ST_ACCEPT) begin
      if (wr_fire) begin
        if (s_last && s_drop) begin
          wr_ptr_nx = wr_commit;
          drop_pkt  = 1'b1;
        end else begin
          store_beat = 1'b1;
          wr_ptr_nx  = wr_ptr + PTR_ONE;
          if (s_last) begin
            wr_commit_nx = wr_ptr + PTR_ONE;
            commit_beat  = 1'b1;
          end else if ((wr_ptr + PTR_ONE - wr_commit) == DEPTH_PTR) begin
            state_nx = ST_DISCARD;
          end
        end
      end
    end else begin
      if (wr_fire && s_last) begin
        wr_ptr_nx = wr_commit;
        drop_pkt  = 1'b1;
        state_nx  = ST_ACCEPT;
      end
    end
    rd_ptr_nx = rd_fire ? (rd_ptr + PTR_ONE) : rd_ptr;
    level_nx  = wr_ptr_nx - rd_ptr_nx;
  end

  // Pointer, FSM and status registers; reset throws away everything including partial packets
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      wr_commit   <= '0;
      rd_ptr      <= '0;
      state       <= ST_ACCEPT;
      level       <= '0;
      almost_full <= 1'b0;
      pkt_count   <= '0;
      drop_pulse  <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nx;
      wr_commit   <= wr_commit_nx;
      rd_ptr      <= rd_ptr_nx;
      state       <= state_nx;
      level       <= level_nx;
      almost_full <= (level_nx >= AF_LEVEL);
      drop_pulse  <= drop_pkt;
      case ({commit_beat, rd_last})
        2'b10:   pkt_count <= pkt_count + PTR_ONE;
        2'b01:   pkt_count <= pkt_count - PTR_ONE;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // Beat storage; contents are deliberately left alone by reset
  always_ff @(posedge clk) begin
    if (store_beat) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_last, s_keep, s_data};
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed checks of a cut-through instance and a packet-mode instance.
module tb_stream_fifo;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int DL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          s0_valid, s0_ready, s0_last, s0_drop;
  logic [DW-1:0] s0_data, m0_data;
  logic [KW-1:0] s0_keep, m0_keep;
  logic          m0_valid, m0_ready, m0_last, af0, drop0;
  logic [DL:0]   level0, pkt0;

  logic          s1_valid, s1_ready, s1_last, s1_drop;
  logic [DW-1:0] s1_data, m1_data;
  logic [KW-1:0] s1_keep, m1_keep;
  logic          m1_valid, m1_ready, m1_last, af1, drop1;
  logic [DL:0]   level1, pkt1;

  int checkCount = 0;
  int passCount  = 0;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  stream_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH_LOG2(DL), .PACKET_MODE(0), .AF_THRESH(6)) u_fifo0 (
    .clk(clk), .rst(rst),
    .s_valid(s0_valid), .s_ready(s0_ready), .s_data(s0_data), .s_keep(s0_keep),
    .s_last(s0_last), .s_drop(s0_drop),
    .m_valid(m0_valid), .m_ready(m0_ready), .m_data(m0_data), .m_keep(m0_keep), .m_last(m0_last),
    .level(level0), .almost_full(af0), .pkt_count(pkt0), .drop_pulse(drop0)
  );

  stream_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH_LOG2(DL), .PACKET_MODE(1), .AF_THRESH(6)) u_fifo1 (
    .clk(clk), .rst(rst),
    .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data), .s_keep(s1_keep),
    .s_last(s1_last), .s_drop(s1_drop),
    .m_valid(m1_valid), .m_ready(m1_ready), .m_data(m1_data), .m_keep(m1_keep), .m_last(m1_last),
    .level(level1), .almost_full(af1), .pkt_count(pkt1), .drop_pulse(drop1)
  );

  // Compare one observed value with its expected value and report any difference
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  // Drive one write beat into the selected instance (0 = cut-through, 1 = packet) and wait one cycle
  task automatic applyStimulus(input bit sel, input logic valid, input logic [DW-1:0] data,
                               input logic last, input logic drop);
    logic [KW-1:0] keep;
    keep = !valid ? 4'h0 : (last ? 4'h3 : 4'hF);
    if (!sel) begin
      s0_valid = valid; s0_data = data; s0_keep = keep; s0_last = last; s0_drop = drop;
    end else begin
      s1_valid = valid; s1_data = data; s1_keep = keep; s1_last = last; s1_drop = drop;
    end
    @(negedge clk);
  endtask

  // Directed sequence; inputs change and outputs are sampled on the falling edge
  initial begin
    s0_valid = 0; s0_data = '0; s0_keep = '0; s0_last = 0; s0_drop = 0; m0_ready = 0;
    s1_valid = 0; s1_data = '0; s1_keep = '0; s1_last = 0; s1_drop = 0; m1_ready = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_s_ready", 64'(s0_ready), 64'(0));
    checkOutput("rst_level", 64'(level0), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready0", 64'(s0_ready), 64'(1));
    checkOutput("post_rst_ready1", 64'(s1_ready), 64'(1));
    checkOutput("post_rst_mvalid", 64'(m0_valid), 64'(0));
    checkOutput("post_rst_mdata", 64'(m0_data), 64'(0));
    checkOutput("post_rst_af", 64'(af0), 64'(0));
    checkOutput("post_rst_pkt", 64'(pkt0), 64'(0));

    // Cut-through fill to full with the consumer stalled
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1'b1, 32'hA000_0000 + 32'(i), i == 7, 1'b0);
      checkOutput("fill_level", 64'(level0), 64'(i + 1));
      checkOutput("fill_af", 64'(af0), 64'((i + 1) >= 6));
      checkOutput("fill_ready", 64'(s0_ready), 64'((i + 1) < 8));
    end
    s0_valid = 0; s0_last = 0;
    checkOutput("fill_mvalid", 64'(m0_valid), 64'(1));
    checkOutput("fill_pkt", 64'(pkt0), 64'(1));

    // Full with a read in the same cycle must still refuse the write
    s0_valid = 1; s0_data = 32'hDEAD_BEEF; m0_ready = 1;
    checkOutput("full_rd_ready", 64'(s0_ready), 64'(0));
    checkOutput("drain_data", 64'(m0_data), 64'h0000_0000_A000_0000);
    @(negedge clk);
    s0_valid = 0;
    checkOutput("full_rd_level", 64'(level0), 64'(7));
    checkOutput("freed_ready", 64'(s0_ready), 64'(1));
    for (int i = 1; i < 8; i++) begin
      checkOutput("drain_data", 64'(m0_data), 64'(32'hA000_0000 + 32'(i)));
      checkOutput("drain_last", 64'(m0_last), 64'(i == 7));
      @(negedge clk);
    end
    m0_ready = 0;
    checkOutput("drain_level", 64'(level0), 64'(0));
    checkOutput("drain_mvalid", 64'(m0_valid), 64'(0));
    checkOutput("drain_pkt", 64'(pkt0), 64'(0));
    checkOutput("empty_mdata", 64'(m0_data), 64'(0));

    // Streaming through the pointer wrap with both sides always ready
    m0_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) checkOutput("stream_data", 64'(m0_data), 64'(32'hB000_0000 + 32'(i - 1)));
      applyStimulus(0, 1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
      checkOutput("stream_level", 64'(level0), 64'(1));
      if (i == 7) checkOutput("wrap_bit_low", 64'(u_fifo0.wr_ptr[DL]), 64'(0));
    end
    s0_valid = 0;
    checkOutput("stream_tail", 64'(m0_data), 64'h0000_0000_B000_0013);
    @(negedge clk);
    m0_ready = 0;
    checkOutput("stream_empty", 64'(level0), 64'(0));
    checkOutput("wrap_ptr", 64'(u_fifo0.wr_ptr), 64'(12));

    // Packet mode: a 3-beat packet stays hidden until its last beat
    applyStimulus(1, 1'b1, 32'hC000_0000, 1'b0, 1'b0);
    checkOutput("pkt3_hidden0", 64'(m1_valid), 64'(0));
    checkOutput("pkt3_level0", 64'(level1), 64'(1));
    applyStimulus(1, 1'b1, 32'hC000_0001, 1'b0, 1'b0);
    checkOutput("pkt3_hidden1", 64'(m1_valid), 64'(0));
    applyStimulus(1, 1'b1, 32'hC000_0002, 1'b1, 1'b0);
    s1_valid = 0; s1_last = 0;
    checkOutput("pkt3_visible", 64'(m1_valid), 64'(1));
    checkOutput("pkt3_pkt", 64'(pkt1), 64'(1));
    checkOutput("pkt3_level", 64'(level1), 64'(3));
    m1_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("pkt3_data", 64'(m1_data), 64'(32'hC000_0000 + 32'(i)));
      checkOutput("pkt3_last", 64'(m1_last), 64'(i == 2));
      checkOutput("pkt3_keep", 64'(m1_keep), (i == 2) ? 64'h3 : 64'hF);
      @(negedge clk);
    end
    m1_ready = 0;
    checkOutput("pkt3_pkt_done", 64'(pkt1), 64'(0));
    checkOutput("pkt3_empty", 64'(m1_valid), 64'(0));

    // Packet mode: a flagged packet is dropped, the following good one survives
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1'b1, 32'hD000_0000 + 32'(i), i == 3, i == 3);
      checkOutput("drop_pulse", 64'(drop1), 64'(i == 3));
      checkOutput("drop_level", 64'(level1), (i == 3) ? 64'(0) : 64'(i + 1));
      checkOutput("drop_hidden", 64'(m1_valid), 64'(0));
    end
    applyStimulus(1, 1'b1, 32'hE000_0000, 1'b0, 1'b0);
    checkOutput("drop_pulse_off", 64'(drop1), 64'(0));
    applyStimulus(1, 1'b1, 32'hE000_0001, 1'b1, 1'b0);
    s1_valid = 0; s1_last = 0;
    checkOutput("good_level", 64'(level1), 64'(2));
    checkOutput("good_visible", 64'(m1_valid), 64'(1));
    m1_ready = 1;
    checkOutput("good_data0", 64'(m1_data), 64'h0000_0000_E000_0000);
    checkOutput("good_last0", 64'(m1_last), 64'(0));
    @(negedge clk);
    checkOutput("good_data1", 64'(m1_data), 64'h0000_0000_E000_0001);
    checkOutput("good_last1", 64'(m1_last), 64'(1));
    @(negedge clk);
    m1_ready = 0;
    checkOutput("good_empty", 64'(m1_valid), 64'(0));
    checkOutput("good_level0", 64'(level1), 64'(0));

    // Packet mode: a 10-beat packet overflows the 8 entries and is discarded whole
    for (int i = 0; i < 10; i++) begin
      checkOutput("over_ready", 64'(s1_ready), 64'(1));
      applyStimulus(1, 1'b1, 32'hF000_0000 + 32'(i), i == 9, 1'b0);
      checkOutput("over_hidden", 64'(m1_valid), 64'(0));
      checkOutput("over_pulse", 64'(drop1), 64'(i == 9));
      checkOutput("over_level", 64'(level1), (i == 9) ? 64'(0) : ((i < 8) ? 64'(i + 1) : 64'(8)));
    end
    s1_valid = 0; s1_last = 0;
    @(negedge clk);
    checkOutput("over_pulse_off", 64'(drop1), 64'(0));
    checkOutput("over_empty", 64'(m1_valid), 64'(0));
    checkOutput("over_ready_after", 64'(s1_ready), 64'(1));

    // Reset in the middle of a packet, then a clean packet afterwards
    applyStimulus(1, 1'b1, 32'h1000_0000, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 32'h1000_0001, 1'b0, 1'b0);
    checkOutput("mid_level", 64'(level1), 64'(2));
    s1_valid = 0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_ready", 64'(s1_ready), 64'(0));
    checkOutput("mid_rst_level", 64'(level1), 64'(0));
    checkOutput("mid_rst_mvalid", 64'(m1_valid), 64'(0));
    checkOutput("mid_rst_pkt", 64'(pkt1), 64'(0));
    checkOutput("mid_rst_af", 64'(af1), 64'(0));
    checkOutput("mid_rst_mdata", 64'(m1_data), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_post_ready", 64'(s1_ready), 64'(1));
    applyStimulus(1, 1'b1, 32'h2000_0000, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 32'h2000_0001, 1'b1, 1'b0);
    s1_valid = 0; s1_last = 0;
    checkOutput("after_level", 64'(level1), 64'(2));
    m1_ready = 1;
    checkOutput("after_data0", 64'(m1_data), 64'h0000_0000_2000_0000);
    @(negedge clk);
    checkOutput("after_data1", 64'(m1_data), 64'h0000_0000_2000_0001);
    checkOutput("after_last1", 64'(m1_last), 64'(1));
    @(negedge clk);
    m1_ready = 0;
    checkOutput("after_empty", 64'(m1_valid), 64'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
